// File: rtl/snn_input_sequencer.sv
// -----------------------------------------------------------------------------
// snn_input_sequencer
//
// Purpose:
//   Buffers one input frame (NUM_INPUTS bytes) from a host byte stream and
//   then runs a spiking-neural-network core for a requested number of ticks
//   against that frame. Each tick is launched with a single-cycle start_tick
//   pulse. The sequencer then waits for the core to raise and drop core_busy.
//   A watchdog aborts the run if the core never acknowledges a tick. Rising
//   edges of neuron_fire are counted during the run, and the counter
//   saturates at its maximum value.
//
// Ports:
//   clk, rst_n          clock (rising edge) / asynchronous active-low reset
//   s_valid, s_data     host frame byte stream (valid/ready handshake)
//   s_ready             sequencer can take a frame byte this cycle
//   run_req, num_ticks  single-cycle run request and its tick count
//   input_read_addr     core-side frame address
//   current_input_val   frame byte at input_read_addr (combinational read)
//   start_tick          single-cycle tick start pulse to the core
//   core_busy           core processing flag
//   neuron_fire         core output spike
//   spike_count         spikes counted in the last run (held until next run)
//   done                single-cycle run-completion pulse
//   seq_busy            FSM is outside IDLE
//   frame_loaded        a complete frame is stored
//   wd_err              sticky watchdog error
// -----------------------------------------------------------------------------
module snn_input_sequencer #(
   parameter int NUM_INPUTS = 256,
   parameter int CNT_W      = 16,
   parameter int WD_CYC     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   input  logic [7:0]       s_data,
   output logic             s_ready,
   input  logic             run_req,
   input  logic [CNT_W-1:0] num_ticks,
   input  logic [7:0]       input_read_addr,
   output logic [7:0]       current_input_val,
   output logic             start_tick,
   input  logic             core_busy,
   input  logic             neuron_fire,
   output logic [CNT_W-1:0] spike_count,
   output logic             done,
   output logic             seq_busy,
   output logic             frame_loaded,
   output logic             wd_err
);

   // The frame address port is 8 bits wide, so NUM_INPUTS is at most 256.
   localparam int AW  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam int WDW = $clog2(WD_CYC + 1);

   localparam logic [AW-1:0]    LAST_IDX = AW'(NUM_INPUTS - 1);
   localparam logic [WDW-1:0]   WD_LAST  = WDW'(WD_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_TICK    = 3'd2;
   localparam logic [2:0] S_WAIT_HI = 3'd3;
   localparam logic [2:0] S_WAIT_LO = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   logic [7:0]       r_mem [NUM_INPUTS];
   logic [2:0]       r_state;
   logic [AW-1:0]    r_wr_idx;
   logic [CNT_W-1:0] r_ticks_left;
   logic [CNT_W-1:0] r_spike_count;
   logic [WDW-1:0]   r_wd_cnt;
   logic             r_frame_loaded;
   logic             r_wd_err;
   logic             r_fire_prev;
   logic             r_done;
   logic             r_alive;

   logic w_run_acc;
   logic w_ready;
   logic w_xfer;
   logic w_fire_edge;
   logic w_count_win;

   // A run request takes priority over a frame byte offered in the same cycle.
   assign w_run_acc   = (r_state == S_IDLE) && run_req && r_frame_loaded;
   // r_alive keeps s_ready low while reset is asserted and until the first
   // clock edge after reset is released.
   assign w_ready     = r_alive && ((r_state == S_IDLE) || (r_state == S_LOAD)) && !w_run_acc;
   assign w_xfer      = s_valid && w_ready;
   assign w_fire_edge = neuron_fire && !r_fire_prev;
   assign w_count_win = (r_state == S_TICK) || (r_state == S_WAIT_HI) ||
                        (r_state == S_WAIT_LO) || (r_state == S_DONE);

   // The frame memory is not reset. frame_loaded gates its use instead.
   always_ff @(posedge clk) begin
      if (w_xfer) begin
         r_mem[r_wr_idx] <= s_data;
      end
   end

   assign current_input_val = (int'(input_read_addr) < NUM_INPUTS) ?
                              r_mem[input_read_addr[AW-1:0]] : 8'h00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_wr_idx       <= '0;
         r_ticks_left   <= '0;
         r_spike_count  <= '0;
         r_wd_cnt       <= '0;
         r_frame_loaded <= 1'b0;
         r_wd_err       <= 1'b0;
         r_fire_prev    <= 1'b0;
         r_done         <= 1'b0;
         r_alive        <= 1'b0;
      end else begin
         r_alive     <= 1'b1;
         r_fire_prev <= neuron_fire;
         // done is registered from the DONE state. A spike edge that occurs
         // during DONE is therefore already in spike_count when done is seen.
         r_done      <= (r_state == S_DONE);

         if (w_run_acc) begin
            r_spike_count <= '0;
         end else if (w_count_win && w_fire_edge && (r_spike_count != CNT_MAX)) begin
            r_spike_count <= r_spike_count + 1'b1;
         end

         case (r_state)
            S_IDLE, S_LOAD: begin
               if (w_run_acc) begin
                  r_ticks_left <= num_ticks;
                  r_wd_err     <= 1'b0;
                  r_state      <= (num_ticks == '0) ? S_DONE : S_TICK;
               end else if (w_xfer) begin
                  if (r_wr_idx == LAST_IDX) begin
                     r_wr_idx       <= '0;
                     r_frame_loaded <= 1'b1;
                     r_state        <= S_IDLE;
                  end else begin
                     r_wr_idx       <= r_wr_idx + 1'b1;
                     r_frame_loaded <= 1'b0;
                     r_state        <= S_LOAD;
                  end
               end
            end
            S_TICK: begin
               r_ticks_left <= r_ticks_left - 1'b1;
               r_wd_cnt     <= '0;
               r_state      <= S_WAIT_HI;
            end
            S_WAIT_HI: begin
               if (core_busy) begin
                  r_state <= S_WAIT_LO;
               end else if (r_wd_cnt == WD_LAST) begin
                  r_wd_err <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_wd_cnt <= r_wd_cnt + 1'b1;
               end
            end
            S_WAIT_LO: begin
               if (!core_busy) begin
                  r_state <= (r_ticks_left != '0) ? S_TICK : S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign s_ready      = w_ready;
   assign start_tick   = (r_state == S_TICK);
   assign done         = r_done;
   assign seq_busy     = (r_state != S_IDLE);
   assign spike_count  = r_spike_count;
   assign frame_loaded = r_frame_loaded;
   assign wd_err       = r_wd_err;

endmodule

// File: tb/tb_snn_input_sequencer.sv
// -----------------------------------------------------------------------------
// tb_snn_input_sequencer
//
// Purpose:
//   Directed test bench for snn_input_sequencer. Expected values are worked
//   out by hand. A second instance with a 4-bit spike counter shares every
//   input with the main instance, so counter saturation can be shown in a
//   short run.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_snn_input_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        run_req;
   logic [15:0] num_ticks;
   logic [7:0]  input_read_addr;
   logic        core_busy;
   logic        neuron_fire;

   logic        s_ready, start_tick, done, seq_busy, frame_loaded, wd_err;
   logic [7:0]  current_input_val;
   logic [15:0] spike_count;

   logic        s_ready_b, start_tick_b, done_b, seq_busy_b, frame_loaded_b, wd_err_b;
   logic [7:0]  current_input_val_b;
   logic [3:0]  spike_count_b;

   int n_cmp = 0;
   int n_bad = 0;
   int ticks_seen, dones_seen, acc_a, acc_b;

   always #5 clk = ~clk;

   snn_input_sequencer dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .run_req(run_req), .num_ticks(num_ticks), .input_read_addr(input_read_addr),
      .current_input_val(current_input_val), .start_tick(start_tick), .core_busy(core_busy),
      .neuron_fire(neuron_fire), .spike_count(spike_count), .done(done), .seq_busy(seq_busy),
      .frame_loaded(frame_loaded), .wd_err(wd_err)
   );

   snn_input_sequencer #(.CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_b),
      .run_req(run_req), .num_ticks(num_ticks[3:0]), .input_read_addr(input_read_addr),
      .current_input_val(current_input_val_b), .start_tick(start_tick_b), .core_busy(core_busy),
      .neuron_fire(neuron_fire), .spike_count(spike_count_b), .done(done_b), .seq_busy(seq_busy_b),
      .frame_loaded(frame_loaded_b), .wd_err(wd_err_b)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Issue a run and act as the core. The core raises busy on the negedge
   // after each start_tick and holds it for busy_cyc cycles. On tick
   // fire_tick it drives 'edges' neuron_fire pulses. Each pulse is high for
   // hi_len cycles and then low for one cycle, and the first pulse starts
   // 10 cycles into busy.
   task automatic run_job(input int n_ticks, input int busy_cyc, input int fire_tick,
                          input int hi_len, input int edges, input bit collide,
                          output int t_seen, output int d_seen);
      int busy_left, tick_no, k, budget;
      t_seen = 0; d_seen = 0; busy_left = 0; tick_no = 0;
      budget = n_ticks * (busy_cyc + 4) + 12;
      @(negedge clk);
      run_req   = 1'b1;
      num_ticks = 16'(n_ticks);
      if (collide) begin
         s_valid = 1'b1;
         s_data  = 8'hAA;
         #1 check_val("run_wins_s_ready", s_ready, 0);
      end
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         run_req = 1'b0;
         s_valid = 1'b0;
         if (start_tick) begin
            t_seen++;
            tick_no   = t_seen;
            busy_left = busy_cyc;
            core_busy = 1'b0;
            neuron_fire = 1'b0;
         end else if (busy_left > 0) begin
            k = busy_cyc - busy_left;
            busy_left--;
            core_busy = 1'b1;
            neuron_fire = (tick_no == fire_tick) && (k >= 10) &&
                          ((k - 10) < edges * (hi_len + 1)) &&
                          (((k - 10) % (hi_len + 1)) < hi_len);
         end else begin
            core_busy = 1'b0;
            neuron_fire = 1'b0;
         end
         if (done) d_seen++;
      end
      core_busy = 1'b0;
      neuron_fire = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; run_req = 1'b0; num_ticks = '0;
      input_read_addr = 8'h00; core_busy = 1'b0; neuron_fire = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check_val("rst_seq_busy", seq_busy, 0);
      check_val("rst_start_tick", start_tick, 0);
      check_val("rst_done", done, 0);
      check_val("rst_spike_count", spike_count, 0);
      check_val("rst_frame_loaded", frame_loaded, 0);
      check_val("rst_wd_err", wd_err, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("post_rst_s_ready", s_ready, 1);

      // run_req without a frame is ignored
      run_req = 1'b1; num_ticks = 16'd3;
      acc_a = 0; acc_b = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         run_req = 1'b0;
         if (start_tick) acc_a++;
         if (seq_busy) acc_b++;
      end
      check_val("noframe_start_ticks", acc_a, 0);
      check_val("noframe_seq_busy", acc_b, 0);

      // Frame load: byte i = i
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         s_valid = 1'b1;
         s_data  = 8'(i);
         if (i == 5) begin
            check_val("load_seq_busy", seq_busy, 1);
            check_val("load_frame_loaded", frame_loaded, 0);
         end
      end
      @(negedge clk);
      s_valid = 1'b0;
      check_val("load_frame_loaded_end", frame_loaded, 1);
      check_val("load_back_idle", seq_busy, 0);
      input_read_addr = 8'h7F;
      #1 check_val("read_7f", current_input_val, 8'h7F);
      input_read_addr = 8'hFF;
      #1 check_val("read_ff", current_input_val, 8'hFF);

      // Three ticks with 258 busy cycles each and a spike on tick 2 only.
      // A byte offered together with run_req must not be taken.
      run_job(3, 258, 2, 3, 1, 1'b1, ticks_seen, dones_seen);
      check_val("run3_start_ticks", ticks_seen, 3);
      check_val("run3_done_pulses", dones_seen, 1);
      check_val("run3_spike_count", spike_count, 1);
      check_val("run3_frame_kept", frame_loaded, 1);
      input_read_addr = 8'h00;
      #1 check_val("run3_byte_refused", current_input_val, 8'h00);

      // num_ticks = 0: done on the cycle after DONE entry, count = 0
      @(negedge clk);
      run_req = 1'b1; num_ticks = 16'd0;
      @(negedge clk);
      run_req = 1'b0;
      check_val("zero_in_done_state", seq_busy, 1);
      check_val("zero_done_not_yet", done, 0);
      @(negedge clk);
      check_val("zero_done_pulse", done, 1);
      check_val("zero_spike_count", spike_count, 0);
      @(negedge clk);
      check_val("zero_done_single", done, 0);

      // A spike edge during the DONE cycle is counted before done shows
      run_req = 1'b1; num_ticks = 16'd0;
      @(negedge clk);
      run_req = 1'b0;
      neuron_fire = 1'b1;
      @(negedge clk);
      neuron_fire = 1'b0;
      check_val("done_edge_done", done, 1);
      check_val("done_edge_count", spike_count, 1);

      // Watchdog: the core never raises busy
      @(negedge clk);
      run_req = 1'b1; num_ticks = 16'd2;
      @(negedge clk);
      run_req = 1'b0;
      check_val("wd_start_tick", start_tick, 1);
      repeat (4) @(negedge clk);
      check_val("wd_not_yet", wd_err, 0);
      @(negedge clk);
      check_val("wd_err_set", wd_err, 1);
      @(negedge clk);
      check_val("wd_done_pulse", done, 1);
      check_val("wd_err_sticky", wd_err, 1);
      run_req = 1'b1; num_ticks = 16'd0;
      @(negedge clk);
      run_req = 1'b0;
      check_val("wd_err_cleared", wd_err, 0);
      repeat (2) @(negedge clk);

      // neuron_fire held high for 10 cycles counts once
      run_job(1, 30, 1, 10, 1, 1'b0, ticks_seen, dones_seen);
      check_val("hold_spike_count", spike_count, 1);
      check_val("hold_done_pulses", dones_seen, 1);

      // 20 edges: the 16-bit counter reaches 20, the 4-bit counter saturates
      run_job(1, 60, 1, 1, 20, 1'b0, ticks_seen, dones_seen);
      check_val("edges20_count", spike_count, 20);
      check_val("sat_count_4b", spike_count_b, 4'hF);

      // Reset during WAIT_LO aborts the run
      @(negedge clk);
      run_req = 1'b1; num_ticks = 16'd2;
      @(negedge clk);
      run_req = 1'b0;
      @(negedge clk);
      core_busy = 1'b1;
      @(negedge clk);
      neuron_fire = 1'b1;
      @(negedge clk);
      neuron_fire = 1'b0;
      @(negedge clk);
      check_val("waitlo_spike_count", spike_count, 1);
      check_val("waitlo_busy", seq_busy, 1);
      rst_n = 1'b0;
      #1;
      check_val("abort_seq_busy", seq_busy, 0);
      check_val("abort_spike_count", spike_count, 0);
      check_val("abort_frame_loaded", frame_loaded, 0);
      check_val("abort_done", done, 0);
      check_val("abort_start_tick", start_tick, 0);
      check_val("abort_s_ready", s_ready, 0);
      @(negedge clk);
      core_busy = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check_val("abort_s_ready_after", s_ready, 1);
      check_val("abort_no_done", done, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/snn_input_sequencer.md
SNN_INPUT_SEQUENCER -- requirements
Module: snn_input_sequencer

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 256, meaning the frame length in bytes; this is also the synapse count of the attached core.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the tick and spike counters.
REQ-003 SHALL have parameter WD_CYC, default 4, meaning the cycles allowed from start_tick to core_busy high.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 s_valid  input  1  host frame byte valid.
REQ-007 s_data  input  8  host frame byte (unsigned input intensity).
REQ-008 s_ready  output  1  sequencer accepts a frame byte.
REQ-009 run_req  input  1  single-cycle request to start a run.
REQ-010 num_ticks  input  CNT_W  number of inference ticks, sampled on run_req.
REQ-011 input_read_addr  input  8  frame address requested by the core.
REQ-012 current_input_val  output  8  frame byte at input_read_addr.
REQ-013 start_tick  output  1  single-cycle tick start pulse to the core.
REQ-014 core_busy  input  1  core processing flag.
REQ-015 neuron_fire  input  1  core output spike.
REQ-016 spike_count  output  CNT_W  spikes counted in the last run; holds until the next run starts.
REQ-017 done  output  1  single-cycle pulse at run completion.
REQ-018 seq_busy  output  1  high in any state except IDLE.
REQ-019 frame_loaded  output  1  a complete frame is present.
REQ-020 wd_err  output  1  sticky watchdog error.

Function
REQ-021 Frame storage SHALL be NUM_INPUTS x 8 bits, with an asynchronous read: current_input_val = mem[input_read_addr] in the same cycle.
REQ-022 The FSM SHALL have exactly these states: IDLE, LOAD, TICK, WAIT_HI, WAIT_LO, DONE.
REQ-023 s_ready SHALL be 1 only in IDLE and LOAD.
REQ-024 A byte SHALL transfer when s_valid and s_ready are both high in the same cycle.
REQ-025 Each transferred byte SHALL be written to mem[wr_idx], and wr_idx SHALL then increment.
REQ-026 A transfer in IDLE SHALL move the FSM to LOAD, clear frame_loaded, and write index 0.
REQ-027 The transfer at wr_idx = NUM_INPUTS-1 SHALL wrap wr_idx to 0, set frame_loaded, and move the FSM to IDLE.
REQ-028 run_req SHALL be accepted only in IDLE with frame_loaded = 1; otherwise it is ignored with no state change.
REQ-029 If run_req coincides with an s_valid transfer in IDLE, run_req SHALL win: s_ready is forced low that cycle and no byte is taken.
REQ-030 On an accepted run_req: ticks_left <= num_ticks, spike_count <= 0, then go to TICK; if num_ticks = 0, go to DONE instead.
REQ-031 TICK SHALL assert start_tick for exactly one cycle, decrement ticks_left, clear the watchdog counter, and go to WAIT_HI.
REQ-032 WAIT_HI SHALL go to WAIT_LO when core_busy = 1.
REQ-033 If core_busy stays low for WD_CYC cycles in WAIT_HI, the block SHALL set wd_err and go to DONE.
REQ-034 WAIT_LO SHALL stay while core_busy = 1.
REQ-035 When core_busy = 0 in WAIT_LO, the FSM SHALL go to TICK if ticks_left != 0, otherwise to DONE.
REQ-036 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-037 Spike counting SHALL increment spike_count on each rising edge of neuron_fire (registered previous value) detected in TICK, WAIT_HI, WAIT_LO or DONE.
REQ-038 spike_count SHALL saturate at all-ones; there is no wrap.
REQ-039 A spike edge coincident with the DONE cycle SHALL be counted before done is observed, so spike_count is final when done = 1.
REQ-040 frame_loaded SHALL remain 1 across runs; the frame is reusable without reload.
REQ-041 wd_err SHALL clear only on reset or on the next accepted run_req.
REQ-042 Memory contents SHALL never be written outside an s_valid & s_ready transfer.

Reset
REQ-043 On rst_n low, the FSM SHALL go to IDLE and wr_idx, ticks_left, spike_count, frame_loaded and wd_err SHALL be 0.
REQ-044 On rst_n low, start_tick, done and seq_busy SHALL be 0; s_ready SHALL become 1 after rst_n release.
REQ-045 Memory contents SHALL not be reset; the frame must be reloaded after reset because frame_loaded = 0.
REQ-046 Reset mid-LOAD or mid-run SHALL abort immediately, with no done pulse.

Verification
REQ-047 Load bytes 0..255 with value = index; drive input_read_addr = 0x7F -> current_input_val = 0x7F same cycle; frame_loaded = 1 after the 256th transfer.
REQ-048 run_req with num_ticks = 3, core model busy for 258 cycles per tick, firing on tick 2 only -> exactly 3 start_tick pulses, spike_count = 1, a single done pulse.
REQ-049 run_req with frame_loaded = 0 -> no start_tick, seq_busy stays 0; run_req with num_ticks = 0 -> done the cycle after DONE entry, spike_count = 0.
REQ-050 Core model never raises busy -> wd_err = 1 after 4 cycles in WAIT_HI, followed by a done pulse; the next run_req clears wd_err.
REQ-051 neuron_fire held high for 10 cycles -> spike_count increments by 1; a preset near-full count with extra edges -> saturates at 0xFFFF.
REQ-052 rst_n asserted during WAIT_LO -> all outputs return to reset values immediately, and s_ready = 1 after release.
